// File: rtl/dual_ram_pkg.sv
// -----------------------------------------------------------------------------
// dual_ram_pkg
// Shared definitions for the dual-port RAM write and read controllers:
// the bank-control FSM state encoding and the default word/address widths.
// -----------------------------------------------------------------------------
package dual_ram_pkg;

   localparam int DEF_DATA_W = 16;
   localparam int DEF_ADDR_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      SEAL = 2'd2,
      WAIT = 2'd3
   } state_t;

endpackage : dual_ram_pkg

// File: rtl/dual_ram_writer_if.sv
// -----------------------------------------------------------------------------
// dual_ram_writer_if
// Bundles the stream input, the RAM write port and the bank handover flags of
// the dual-port RAM writer.
//   s_valid/s_data/s_ready : valid/ready input word stream
//   wr_en/wr_addr/wr_data  : RAM write port, wr_addr = {bank, offset}
//   bank_full              : per-bank "complete block ready for reader"
//   bank_release           : per-bank one-cycle "reader done" pulse
// Modport master is the writer; modport slave is the surrounding system.
// -----------------------------------------------------------------------------
interface dual_ram_writer_if
   import dual_ram_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
);

   logic              s_valid;
   logic [DATA_W-1:0] s_data;
   logic              s_ready;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic [1:0]        bank_full;
   logic [1:0]        bank_release;

   modport master (
      input  s_valid,
      input  s_data,
      output s_ready,
      output wr_en,
      output wr_addr,
      output wr_data,
      output bank_full,
      input  bank_release
   );

   modport slave (
      output s_valid,
      output s_data,
      input  s_ready,
      input  wr_en,
      input  wr_addr,
      input  wr_data,
      input  bank_full,
      output bank_release
   );

endinterface : dual_ram_writer_if

// File: rtl/dual_ram_writer.sv
// -----------------------------------------------------------------------------
// dual_ram_writer
// Write-side controller of the dual-port RAM. Accepts a valid/ready word
// stream and writes it into two ping-pong banks (bank = address MSB). When a
// bank's last word has been written the bank is flagged full and handed to
// the reader, which hands it back with a release pulse.
// Ports:
//   sclk   : system clock, rising edge
//   srst_n : asynchronous active-low reset
//   bus    : dual_ram_writer_if.master (stream in, RAM write port, bank flags)
// -----------------------------------------------------------------------------
module dual_ram_writer
   import dual_ram_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic               sclk,
   input  logic               srst_n,
   dual_ram_writer_if.master  bus
);

   localparam int               OFF_W    = ADDR_W - 1;
   localparam logic [OFF_W-1:0] OFF_LAST = {OFF_W{1'b1}};

   state_t            state_r;
   state_t            next_state_s;
   logic              cur_bank_r;
   logic [OFF_W-1:0]  offset_r;
   logic              wr_en_r;
   logic [ADDR_W-1:0] wr_addr_r;
   logic [DATA_W-1:0] wr_data_r;
   logic [1:0]        bank_full_r;
   logic              s_ready_s;
   logic              accept_s;
   logic [1:0]        set_full_s;

   assign accept_s      = bus.s_valid & s_ready_s;

   assign bus.s_ready   = s_ready_s;
   assign bus.wr_en     = wr_en_r;
   assign bus.wr_addr   = wr_addr_r;
   assign bus.wr_data   = wr_data_r;
   assign bus.bank_full = bank_full_r;

   // FSM state register
   always_ff @(posedge sclk or negedge srst_n) begin
      if (!srst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state and ready decode; s_ready depends on registered state only
   always_comb begin
      next_state_s = state_r;
      s_ready_s    = 1'b0;
      case (state_r)
         IDLE: begin
            next_state_s = FILL;
         end
         FILL: begin
            s_ready_s = ~bank_full_r[cur_bank_r];
            if (bus.s_valid && !bank_full_r[cur_bank_r] && (offset_r == OFF_LAST)) begin
               next_state_s = SEAL;
            end else begin
               next_state_s = FILL;
            end
         end
         SEAL: begin
            // The bank about to be entered is judged on its registered flag;
            // a release arriving on this same edge is only seen from WAIT.
            if (bank_full_r[~cur_bank_r]) begin
               next_state_s = WAIT;
            end else begin
               next_state_s = FILL;
            end
         end
         WAIT: begin
            if (!bank_full_r[cur_bank_r]) begin
               next_state_s = FILL;
            end else begin
               next_state_s = WAIT;
            end
         end
         default: begin
            next_state_s = IDLE;
         end
      endcase
   end

   // Full-flag set request: raised during SEAL, when the last word is in RAM
   always_comb begin
      set_full_s = 2'b00;
      if (state_r == SEAL) begin
         set_full_s[cur_bank_r] = 1'b1;
      end else begin
         set_full_s = 2'b00;
      end
   end

   // RAM write port, bank/offset counters and the per-bank full flags
   always_ff @(posedge sclk or negedge srst_n) begin
      if (!srst_n) begin
         wr_en_r     <= 1'b0;
         wr_addr_r   <= '0;
         wr_data_r   <= '0;
         cur_bank_r  <= 1'b0;
         offset_r    <= '0;
         bank_full_r <= 2'b00;
      end else begin
         wr_en_r <= accept_s;
         if (accept_s) begin
            wr_addr_r <= {cur_bank_r, offset_r};
            wr_data_r <= bus.s_data;
            offset_r  <= offset_r + OFF_W'(1);
         end
         if (state_r == SEAL) begin
            cur_bank_r <= ~cur_bank_r;
            offset_r   <= '0;
         end
         // Set takes priority over a simultaneous release of the same bank;
         // releasing a bank that is not full leaves it clear.
         bank_full_r <= (bank_full_r & ~bus.bank_release) | set_full_s;
      end
   end

endmodule : dual_ram_writer

// File: tb/tb_dual_ram_writer.sv
// -----------------------------------------------------------------------------
// tb_dual_ram_writer
// Directed and randomized bench for dual_ram_writer with 8-word banks
// (ADDR_W=4, DATA_W=16). A word-count based reference model predicts
// s_ready, the RAM write stream and the bank_full flags every cycle.
// -----------------------------------------------------------------------------
module tb_dual_ram_writer;

   localparam int DW   = 16;
   localparam int AW   = 4;
   localparam int BANK = 8;
   localparam int WRAP = 16;

   logic sclk   = 1'b0;
   logic srst_n = 1'b0;

   always #5 sclk = ~sclk;

   dual_ram_writer_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

   dual_ram_writer #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .sclk   (sclk),
      .srst_n (srst_n),
      .bus    (bus.master)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: everything is derived from the number of words
   // accepted since reset (address = count mod 16, bank = address MSB).
   bit          m_idle;        // first cycle after reset: nothing accepted
   bit          m_seal;        // cycle right after a bank's last word
   int          m_seal_bank;
   int          m_cnt;
   logic [1:0]  m_full;
   logic [1:0]  m_full_prev;  // flags as seen one cycle earlier
   bit          m_wr_en;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_data;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // The writer only takes words into a bank that has been seen empty for a
   // whole cycle, never during the first cycle out of reset or the seal bubble.
   function automatic bit exp_ready();
      int b;
      b = (m_cnt / BANK) % 2;
      return !m_idle && !m_seal && !m_full[b] && !m_full_prev[b];
   endfunction

   task automatic model_reset();
      m_idle      = 1'b1;
      m_seal      = 1'b0;
      m_seal_bank = 0;
      m_cnt       = 0;
      m_full      = 2'b00;
      m_full_prev = 2'b00;
      m_wr_en     = 1'b0;
      m_addr      = '0;
      m_data      = '0;
   endtask

   task automatic check_outputs();
      chk("s_ready", 32'(bus.s_ready), 32'(exp_ready()));
      chk("wr_en", 32'(bus.wr_en), 32'(m_wr_en));
      chk("bank_full", 32'(bus.bank_full), 32'(m_full));
      if (m_wr_en) begin
         chk("wr_addr", 32'(bus.wr_addr), 32'(m_addr));
         chk("wr_data", 32'(bus.wr_data), 32'(m_data));
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_s_ready"},   32'(bus.s_ready),   32'h0);
      chk({tag, "_wr_en"},     32'(bus.wr_en),     32'h0);
      chk({tag, "_wr_addr"},   32'(bus.wr_addr),   32'h0);
      chk({tag, "_wr_data"},   32'(bus.wr_data),   32'h0);
      chk({tag, "_bank_full"}, 32'(bus.bank_full), 32'h0);
   endtask

   // One clock cycle: drive, check, clock, advance the model.
   task automatic cycle(input bit v, input logic [DW-1:0] d, input logic [1:0] rel, output bit acc);
      logic [1:0] setm;
      bus.s_valid      = v;
      bus.s_data       = d;
      bus.bank_release = rel;
      #1;
      check_outputs();
      acc = v && exp_ready();
      @(posedge sclk);
      #1;
      setm        = m_seal ? (2'b01 << m_seal_bank) : 2'b00;
      m_full_prev = m_full;
      m_full      = (m_full & ~rel) | setm;
      m_wr_en     = acc;
      m_seal      = 1'b0;
      if (acc) begin
         m_addr      = AW'(m_cnt);
         m_data      = d;
         m_seal      = (m_cnt % BANK) == (BANK - 1);
         m_seal_bank = m_cnt / BANK;
         m_cnt       = (m_cnt + 1) % WRAP;
      end
      m_idle = 1'b0;
   endtask

   task automatic do_reset(input int n);
      srst_n           = 1'b0;
      bus.s_valid      = 1'b0;
      bus.s_data       = '0;
      bus.bank_release = 2'b00;
      model_reset();
      #1;
      check_zero("rst_async");
      repeat (n) @(posedge sclk);
      #1;
      check_zero("rst_held");
      srst_n = 1'b1;
   endtask

   // Push n words; optional bubbles and a stray release while filling.
   task automatic feed(input int n, input bit bubbles, input bit rnd,
                       input logic [DW-1:0] base, input logic [1:0] stray);
      int k;
      int budget;
      bit acc;
      bit v;
      logic [DW-1:0] d;
      k      = 0;
      budget = 4 * n + 40;
      v      = 1'b1;
      while (k < n && budget > 0) begin
         d = rnd ? DW'($urandom) : base + DW'(k);
         cycle(v, d, (bubbles && k == 2) ? stray : 2'b00, acc);
         if (acc) k++;
         if (bubbles) v = ~v;
         budget--;
      end
      checks++;
      assert (k == n) else begin
         errors++;
         $error("FAIL feed_timeout: accepted %0d required %0d", k, n);
      end
   endtask

   initial begin
      bit acc;
      bit v;
      logic [1:0] rel;

      bus.s_valid      = 1'b0;
      bus.s_data       = '0;
      bus.bank_release = 2'b00;

      // Reset for 3 cycles, then stream bank 0 with 0x0100..0x0107
      do_reset(3);
      feed(BANK, 1'b0, 1'b0, 16'h0100, 2'b00);
      chk("seal_ready", 32'(bus.s_ready), 32'h0);
      chk("last_addr", 32'(bus.wr_addr), 32'h7);
      cycle(1'b0, 16'h0000, 2'b00, acc);
      chk("bank0_full", 32'(bus.bank_full), 32'h1);

      // Fill bank 1 too; no release, so the writer must stall
      feed(BANK, 1'b0, 1'b1, 16'h0000, 2'b00);
      repeat (20) cycle(1'b1, DW'($urandom), 2'b00, acc);
      chk("both_full", 32'(bus.bank_full), 32'h3);
      chk("wait_ready", 32'(bus.s_ready), 32'h0);

      // Release bank 0: flag clears next cycle, ready one cycle later
      cycle(1'b0, 16'h0000, 2'b01, acc);
      chk("release0_full", 32'(bus.bank_full), 32'h2);
      cycle(1'b0, 16'h0000, 2'b00, acc);
      chk("release0_ready", 32'(bus.s_ready), 32'h1);
      feed(BANK, 1'b0, 1'b1, 16'h0000, 2'b00);
      cycle(1'b0, 16'h0000, 2'b00, acc);
      chk("refill_full", 32'(bus.bank_full), 32'h3);

      // Release both banks on the same edge
      cycle(1'b0, 16'h0000, 2'b11, acc);
      chk("release_both", 32'(bus.bank_full), 32'h0);

      // Bubbles plus a stray release of empty bank 1 while filling it
      feed(BANK, 1'b1, 1'b0, 16'hA000, 2'b10);
      // Release bank 1 during its own seal: the set must win
      cycle(1'b0, 16'h0000, 2'b10, acc);
      chk("set_wins", 32'(bus.bank_full), 32'h2);

      // Randomized traffic with occasional releases
      repeat (200) begin
         v   = ($urandom_range(0, 3) != 0);
         rel = ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b00;
         cycle(v, DW'($urandom), rel, acc);
      end

      // Reset in the middle of a bank fill, then restart from address 0
      do_reset(2);
      feed(5, 1'b0, 1'b1, 16'h0000, 2'b00);
      do_reset(2);
      feed(4, 1'b0, 1'b1, 16'h0000, 2'b00);
      chk("restart_addr", 32'(bus.wr_addr), 32'h3);
      cycle(1'b0, 16'h0000, 2'b00, acc);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_dual_ram_writer
